// File: rtl/coin_acceptor_pkg.sv
// Purpose: shared FSM encoding, coin codes/values and default timing for the coin acceptor.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package coin_acceptor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DEBOUNCE   = 3'd1,
    ST_EMIT       = 3'd2,
    ST_WAIT_CLEAR = 3'd3,
    ST_JAM        = 3'd4
  } state_t;

  // Code driven on {i,j}; 2'b11 is never produced.
  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_5    = 2'b01,
    COIN_10   = 2'b10
  } coin_t;

  localparam int unsigned VAL_5             = 5;
  localparam int unsigned VAL_10            = 10;
  localparam int unsigned DEB_DEFAULT       = 4;
  localparam int unsigned JAM_LIMIT_DEFAULT = 32;

  // 8-bit add that clamps at 255 instead of wrapping.
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/coin_acceptor_sync2.sv
// Purpose: two-flop synchronizer bringing an asynchronous sensor level into the clk domain.
// Latency: 2 clk cycles from first sampling edge to q.
// Backpressure: none; free-running, level in / level out.
//
// Ports: clk - sampling clock; reset - synchronous active-high clear of both flops;
//        d - asynchronous input level; q - synchronized level.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// Purpose: debounces two coin sensors, emits a one-cycle coin code, keeps a saturating total, detects jams.
// Latency: raw line first sampled at edge 0 -> code registered at edge DEB+1, cleared at edge DEB+2.
// Backpressure: none; accept_en low turns an accepted coin into a reject pulse, JAM ignores all coins.
//
// Ports: clk, reset (sync active-high); coin5_raw/coin10_raw async sensor levels;
//        accept_en gate for accepting coins; jam_clr one-cycle jam release request;
//        i/j coin code MSB/LSB; reject one-cycle pulse; jam level; total 8-bit running value.
module coin_acceptor
  import coin_acceptor_pkg::*;
#(
  parameter int unsigned DEB       = DEB_DEFAULT,
  parameter int unsigned JAM_LIMIT = JAM_LIMIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin5_raw,
  input  logic       coin10_raw,
  input  logic       accept_en,
  input  logic       jam_clr,
  output logic       i,
  output logic       j,
  output logic       reject,
  output logic       jam,
  output logic [7:0] total
);

  localparam logic [3:0] DEB_LAST = 4'(DEB - 1);
  localparam logic [7:0] JAM_LAST = 8'(JAM_LIMIT - 1);

  logic       s5;
  logic       s10;
  state_t     state;
  coin_t      coin;
  logic [3:0] cnt;
  logic [7:0] timer;

  logic       latched_hi;
  logic       other_hi;
  logic [7:0] coin_val;

  sync2 u_sync5 (
    .clk   (clk),
    .reset (reset),
    .d     (coin5_raw),
    .q     (s5)
  );

  sync2 u_sync10 (
    .clk   (clk),
    .reset (reset),
    .d     (coin10_raw),
    .q     (s10)
  );

  // Lines viewed relative to the coin type latched on leaving IDLE.
  always_comb begin
    latched_hi = 1'b0;
    other_hi   = 1'b0;
    coin_val   = 8'(VAL_10);
    if (coin == COIN_5) begin
      latched_hi = s5;
      other_hi   = s10;
      coin_val   = 8'(VAL_5);
    end else begin
      latched_hi = s10;
      other_hi   = s5;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      coin   <= COIN_NONE;
      cnt    <= 4'd0;
      timer  <= 8'd0;
      i      <= 1'b0;
      j      <= 1'b0;
      reject <= 1'b0;
      jam    <= 1'b0;
      total  <= 8'd0;
    end else begin
      // Pulse outputs default low so each is high for at most one cycle.
      i      <= 1'b0;
      j      <= 1'b0;
      reject <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (s5 && s10) begin
            reject <= 1'b1;
            timer  <= 8'd0;
            state  <= ST_WAIT_CLEAR;
          end else if (s5 ^ s10) begin
            coin  <= s5 ? COIN_5 : COIN_10;
            cnt   <= 4'd1;
            state <= ST_DEBOUNCE;
          end
        end

        ST_DEBOUNCE: begin
          if (other_hi) begin
            reject <= 1'b1;
            cnt    <= 4'd0;
            timer  <= 8'd0;
            state  <= ST_WAIT_CLEAR;
          end else if (!latched_hi) begin
            // Glitch: drop silently.
            cnt   <= 4'd0;
            state <= ST_IDLE;
          end else if (cnt == DEB_LAST) begin
            // The EMIT decision is registered on the edge that enters EMIT so
            // the code/reject pulse occupies exactly the EMIT cycle; this is
            // the only place accept_en is looked at.
            cnt   <= 4'd0;
            state <= ST_EMIT;
            if (accept_en) begin
              {i, j} <= coin;
              total  <= sat_add(total, coin_val);
            end else begin
              reject <= 1'b1;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        ST_EMIT: begin
          timer <= 8'd0;
          state <= ST_WAIT_CLEAR;
        end

        ST_WAIT_CLEAR: begin
          if (!s5 && !s10) begin
            timer <= 8'd0;
            state <= ST_IDLE;
          end else if (timer == JAM_LAST) begin
            // This edge is the JAM_LIMIT-th cycle since entry.
            timer <= 8'd0;
            jam   <= 1'b1;
            state <= ST_JAM;
          end else begin
            timer <= timer + 8'd1;
          end
        end

        ST_JAM: begin
          if (jam_clr && !s5 && !s10) begin
            jam   <= 1'b0;
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Purpose: directed self-checking bench for coin_acceptor (DEB=4, JAM_LIMIT=32).
// Latency: n/a.
// Backpressure: n/a.
module tb_coin_acceptor;

  logic       clk = 1'b0;
  logic       reset;
  logic       coin5_raw;
  logic       coin10_raw;
  logic       accept_en;
  logic       jam_clr;
  logic       i;
  logic       j;
  logic       reject;
  logic       jam;
  logic [7:0] total;

  int checks = 0;
  int errors = 0;
  int exp_total;

  always #5 clk = ~clk;

  coin_acceptor dut (
    .clk        (clk),
    .reset      (reset),
    .coin5_raw  (coin5_raw),
    .coin10_raw (coin10_raw),
    .accept_en  (accept_en),
    .jam_clr    (jam_clr),
    .i          (i),
    .j          (j),
    .reject     (reject),
    .jam        (jam),
    .total      (total)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset      = 1'b1;
    coin5_raw  = 1'b0;
    coin10_raw = 1'b0;
    accept_en  = 1'b1;
    jam_clr    = 1'b0;
    tick();
    tick();
    chk("rst_code",   {6'd0, i, j}, 8'd0);
    chk("rst_reject", {7'd0, reject}, 8'd0);
    chk("rst_jam",    {7'd0, jam}, 8'd0);
    chk("rst_total",  total, 8'd0);
    reset = 1'b0;
    tick();

    // 5-unit coin held 10 cycles: code 01 on edge 5 only.
    coin5_raw = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("c5_code", {6'd0, i, j}, (k == 5) ? 8'd1 : 8'd0);
      chk("c5_reject", {7'd0, reject}, 8'd0);
    end
    coin5_raw = 1'b0;
    chk("c5_total", total, 8'd5);
    repeat (6) tick();

    // 2-cycle glitch on the 10-unit line is filtered.
    coin10_raw = 1'b1;
    tick();
    tick();
    coin10_raw = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("glitch_code", {6'd0, i, j}, 8'd0);
      chk("glitch_reject", {7'd0, reject}, 8'd0);
    end
    chk("glitch_total", total, 8'd5);

    // Both lines together: one reject two edges after sampling.
    coin5_raw  = 1'b1;
    coin10_raw = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("both_reject", {7'd0, reject}, (k == 2) ? 8'd1 : 8'd0);
      chk("both_code", {6'd0, i, j}, 8'd0);
    end
    coin5_raw  = 1'b0;
    coin10_raw = 1'b0;
    repeat (4) tick();
    chk("both_total", total, 8'd5);

    // accept_en low: valid 10-unit coin is rejected instead of counted.
    accept_en  = 1'b0;
    coin10_raw = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("dis_reject", {7'd0, reject}, (k == 5) ? 8'd1 : 8'd0);
      chk("dis_code", {6'd0, i, j}, 8'd0);
    end
    coin10_raw = 1'b0;
    repeat (6) tick();
    accept_en = 1'b1;
    chk("dis_total", total, 8'd5);

    // 10-unit line stuck high: one code, jam 32 cycles after WAIT_CLEAR entry (edge 6).
    coin10_raw = 1'b1;
    for (int k = 0; k < 60; k++) begin
      jam_clr = (k == 45);
      tick();
      chk("stuck_code", {6'd0, i, j}, (k == 5) ? 8'd2 : 8'd0);
      chk("stuck_jam", {7'd0, jam}, (k >= 38) ? 8'd1 : 8'd0);
    end
    jam_clr    = 1'b0;
    coin10_raw = 1'b0;
    repeat (3) tick();
    chk("jam_hold", {7'd0, jam}, 8'd1);
    jam_clr = 1'b1;
    tick();
    jam_clr = 1'b0;
    chk("jam_clear", {7'd0, jam}, 8'd0);
    chk("stuck_total", total, 8'd15);

    // 26 more 10-unit coins: total clamps at 255.
    exp_total = 15;
    for (int n = 0; n < 26; n++) begin
      coin10_raw = 1'b1;
      repeat (7) tick();
      coin10_raw = 1'b0;
      repeat (6) tick();
      exp_total = (exp_total + 10 > 255) ? 255 : exp_total + 10;
      chk("sat_total", total, 8'(exp_total));
    end

    // Reset during DEBOUNCE discards the coin; a line still high afterwards is a new coin.
    coin5_raw = 1'b1;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_code",   {6'd0, i, j}, 8'd0);
    chk("mid_rst_reject", {7'd0, reject}, 8'd0);
    chk("mid_rst_jam",    {7'd0, jam}, 8'd0);
    chk("mid_rst_total",  total, 8'd0);
    tick();
    chk("mid_rst_code2",  {6'd0, i, j}, 8'd0);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("post_rst_code", {6'd0, i, j}, (k == 5) ? 8'd1 : 8'd0);
    end
    chk("post_rst_total", total, 8'd5);
    coin5_raw = 1'b0;
    repeat (6) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter DEB, default 4: consecutive synchronized-high cycles needed to accept a coin (legal range 2..15).
REQ-002 Parameter JAM_LIMIT, default 32: WAIT_CLEAR cycles before declaring a jam (legal range DEB+1..255).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 coin5_raw  input  1  raw level from the 5-unit coin sensor, asynchronous to clk.
REQ-006 coin10_raw  input  1  raw level from the 10-unit coin sensor, asynchronous to clk.
REQ-007 accept_en  input  1  high means coins may be accepted; low means every coin is rejected.
REQ-008 jam_clr  input  1  single-cycle request to leave JAM.
REQ-009 i  output  1  coin code MSB, driven to the downstream vending FSM.
REQ-010 j  output  1  coin code LSB.
REQ-011 reject  output  1  one-cycle pulse when a coin is rejected.
REQ-012 jam  output  1  level; high while in JAM.
REQ-013 total  output  8  running value of accepted coins.

Function
REQ-014 Each raw input shall pass through a 2-flop synchronizer; all logic below uses the synchronized values s5 and s10.
REQ-015 Coin code {i,j}: 2'b00 = no coin, 2'b01 = 5-unit coin, 2'b10 = 10-unit coin; 2'b11 shall never be driven.
REQ-016 FSM states: IDLE, DEBOUNCE, EMIT, WAIT_CLEAR, JAM.
REQ-017 IDLE, exactly one of s5/s10 high: latch coin type, set cnt=1, go to DEBOUNCE.
REQ-018 IDLE, both s5 and s10 high: pulse reject, go to WAIT_CLEAR.
REQ-019 DEBOUNCE, latched line high and cnt<DEB-1: increment cnt and stay.
REQ-020 DEBOUNCE, latched line low before cnt reaches DEB-1: go to IDLE; no code, no reject (glitch filtered).
REQ-021 DEBOUNCE, the other line goes high: pulse reject, go to WAIT_CLEAR.
REQ-022 DEBOUNCE, cnt==DEB-1 and line still high: go to EMIT.
REQ-023 EMIT lasts one cycle, then goes to WAIT_CLEAR.
REQ-024 EMIT with accept_en high: {i,j}=coin code for exactly that cycle, and total adds 5 or 10, saturating at 255.
REQ-025 EMIT with accept_en low: {i,j}=00, reject=1, total unchanged.
REQ-026 Outputs i, j and reject shall be registered; each is high for at most one cycle per coin.
REQ-027 Latency: with a raw line held high and first sampled at edge 0, the code is valid from edge DEB+1 to edge DEB+2.
REQ-028 WAIT_CLEAR, both s5 and s10 low: go to IDLE; a new coin is never counted before the previous one clears.
REQ-029 WAIT_CLEAR timer counts from entry; when the timer reaches JAM_LIMIT with any line still high, go to JAM.
REQ-030 JAM: jam=1, no codes emitted, all coins ignored (no reject pulses).
REQ-031 JAM exits to IDLE only when jam_clr=1 and s5=s10=0 in the same cycle; jam_clr in any other state has no effect.
REQ-032 accept_en is sampled only in EMIT.

Reset
REQ-033 reset=1 at any clock edge: state IDLE, cnt=0, WAIT_CLEAR timer=0, synchronizers cleared.
REQ-034 reset=1 at any clock edge: i=0, j=0, reject=0, jam=0, total=0.
REQ-035 Reset mid-coin (DEBOUNCE or EMIT) discards that coin.
REQ-036 After reset releases, a line still high is treated as a new insertion from IDLE.

Structure
REQ-037 A shared package holds the FSM state encoding, coin codes 2'b01/2'b10, coin values 5/10, and default DEB/JAM_LIMIT.
REQ-038 One sub-module, sync2 (2-flop synchronizer), is instantiated twice; everything else is flat.

Verification
REQ-039 coin5_raw high 10 cycles, DEB=4 -> {i,j}=01 for one cycle, 5 cycles after first sampling edge; total=5.
REQ-040 coin10_raw high for 2 cycles (glitch) -> no code, no reject, total unchanged.
REQ-041 coin5_raw and coin10_raw rise together -> reject for one cycle, {i,j}=00, then IDLE once both lines are low.
REQ-042 accept_en=0 with a valid coin10 insertion -> reject for one cycle, total unchanged.
REQ-043 coin10_raw held high 60 cycles -> one code 10; jam=1 at WAIT_CLEAR entry+32.
REQ-043a Continuing REQ-043: jam_clr while line high is ignored; jam_clr after line low -> jam=0.
REQ-044 Inject 26 coin10 insertions -> total saturates at 255.
REQ-044a reset asserted during DEBOUNCE -> no code and all outputs 0 on the next cycle.
